// File: rtl/pcileech_tlp_arb_pkg.sv
// Shared types and widths for the PCIe TX TLP arbiter and its skid stage.
package pcileech_tlp_arb_pkg;

    localparam int TLP_DATA_W = 64;
    localparam int TLP_KEEP_W = 8;
    localparam int TLP_USER_W = 22;

    typedef struct packed {
        logic [TLP_DATA_W-1:0] data;
        logic [TLP_KEEP_W-1:0] keep;
        logic [TLP_USER_W-1:0] user;
        logic                  last;
    } tlp_beat_t;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

endpackage

// File: rtl/pcileech_tlp_skid64.sv
// Two-entry register slice for TLP beats; outputs come straight from the head register
// so the core-facing interface is fully registered.
module pcileech_tlp_skid64
    import pcileech_tlp_arb_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  tlp_beat_t in_beat,
    input  logic      in_valid,
    output logic      in_ready,
    output tlp_beat_t out_beat,
    output logic      out_valid,
    input  logic      out_ready
);

    tlp_beat_t  r_head;
    tlp_beat_t  r_skid;
    logic [1:0] r_cnt;
    logic       w_push;
    logic       w_pop;

    assign in_ready  = (r_cnt != 2'd2);
    assign out_valid = (r_cnt != 2'd0);
    assign out_beat  = r_head;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // When full the pop drains the skid entry into the head; in_ready was already low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head <= '0;
            r_skid <= '0;
            r_cnt  <= 2'd0;
        end else begin
            case (r_cnt)
                2'd0: begin
                    if (w_push) begin
                        r_head <= in_beat;
                        r_cnt  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_head <= in_beat;
                    end else if (w_push) begin
                        r_skid <= in_beat;
                        r_cnt  <= 2'd2;
                    end else if (w_pop) begin
                        r_cnt  <= 2'd0;
                    end
                end
                default: begin
                    if (w_pop) begin
                        r_head <= r_skid;
                        r_cnt  <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/pcileech_tlp_tx_arb.sv
// Packet-level arbiter sharing the 64-bit PCIe TX TLP stream between NUM_SRC producers;
// whole TLPs only, round-robin with optional strict priority for source 0.
module pcileech_tlp_tx_arb
    import pcileech_tlp_arb_pkg::*;
#(
    parameter int NUM_SRC     = 3,
    parameter int PRIO0       = 0,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*TLP_DATA_W-1:0] s_data,
    input  logic [NUM_SRC*TLP_KEEP_W-1:0] s_keep,
    input  logic [NUM_SRC*TLP_USER_W-1:0] s_user,
    input  logic [NUM_SRC-1:0]            s_last,
    input  logic [NUM_SRC-1:0]            s_valid,
    output logic [NUM_SRC-1:0]            s_ready,
    input  logic [NUM_SRC-1:0]            src_en,
    output logic [TLP_DATA_W-1:0]         m_data,
    output logic [TLP_KEEP_W-1:0]         m_keep,
    output logic [TLP_USER_W-1:0]         m_user,
    output logic                          m_last,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(NUM_SRC)-1:0]    grant_id,
    output logic                          busy,
    output logic                          stall_err,
    output logic [15:0]                   pkt_cnt
);

    localparam int GW = $clog2(NUM_SRC);
    localparam int SW = $clog2(TIMEOUT_CYC + 1);

    arb_state_e      r_state;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   r_rr_ptr;
    logic [SW-1:0]   r_stall;
    logic            r_stall_err;
    logic [15:0]     r_pkt_cnt;

    logic [NUM_SRC-1:0] w_elig;
    logic [GW-1:0]      w_winner;
    logic [GW-1:0]      w_idx;
    logic               w_found;
    tlp_beat_t          w_in_beat;
    tlp_beat_t          w_out_beat;
    logic               w_sel_valid;
    logic               w_in_valid;
    logic               w_in_ready;
    logic               w_xfer_beat;

    assign w_elig = s_valid & src_en;

    // Search rr_ptr+1, rr_ptr+2, ... so the last winner becomes lowest priority.
    always_comb begin
        w_winner = r_rr_ptr;
        w_found  = 1'b0;
        w_idx    = '0;
        if (PRIO0 != 0 && w_elig[0]) begin
            w_winner = '0;
            w_found  = 1'b1;
        end else begin
            for (int i = 1; i <= NUM_SRC; i++) begin
                w_idx = GW'((int'(r_rr_ptr) + i) % NUM_SRC);
                if (!w_found && w_elig[w_idx]) begin
                    w_winner = w_idx;
                    w_found  = 1'b1;
                end
            end
        end
    end

    assign w_in_beat = '{data: s_data[r_grant*TLP_DATA_W +: TLP_DATA_W],
                         keep: s_keep[r_grant*TLP_KEEP_W +: TLP_KEEP_W],
                         user: s_user[r_grant*TLP_USER_W +: TLP_USER_W],
                         last: s_last[r_grant]};
    assign w_sel_valid = s_valid[r_grant];
    assign w_in_valid  = (r_state == XFER) && w_sel_valid;
    assign w_xfer_beat = w_in_valid && w_in_ready;

    always_comb begin
        s_ready = '0;
        if (r_state == XFER) s_ready[r_grant] = w_in_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= GW'(NUM_SRC - 1);
            r_stall     <= '0;
            r_stall_err <= 1'b0;
        end else begin
            r_stall_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant  <= w_winner;
                        r_rr_ptr <= w_winner;
                        r_stall  <= '0;
                        r_state  <= XFER;
                    end
                end
                XFER: begin
                    if (w_xfer_beat) begin
                        r_stall <= '0;
                        if (w_in_beat.last) r_state <= IDLE;
                    end else if (!w_sel_valid && r_stall != SW'(TIMEOUT_CYC)) begin
                        r_stall <= r_stall + SW'(1);
                        if (r_stall == SW'(TIMEOUT_CYC - 1)) r_stall_err <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    pcileech_tlp_skid64 u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_beat   (w_in_beat),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .out_beat  (w_out_beat),
        .out_valid (m_valid),
        .out_ready (m_ready)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pkt_cnt <= 16'd0;
        end else if (m_valid && m_ready && m_last) begin
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
        end
    end

    assign m_data    = w_out_beat.data;
    assign m_keep    = w_out_beat.keep;
    assign m_user    = w_out_beat.user;
    assign m_last    = w_out_beat.last;
    assign grant_id  = r_grant;
    assign busy      = (r_state == XFER);
    assign stall_err = r_stall_err;
    assign pkt_cnt   = r_pkt_cnt;

endmodule
